// File: rtl/voice_allocator.sv
// voice_allocator: polyphony scheduler between the note decoder gates and the
// per-slot sine/ADSR datapath. Gate edges are registered, note-ons are queued in
// a pending mask and served one per cycle (lowest note first) onto playback
// slots, each running a FREE -> HOLD -> RELEASE -> FREE state machine.
// Optional feature macro: VOICE_STEAL_EN -- when defined, a note-on that finds
// no FREE or RELEASE slot steals the oldest HOLD slot; when undefined such a
// note-on is discarded and drop_out pulses.
module voice_allocator #(
    parameter int NUM_NOTES       = 8,
    parameter int NUM_VOICES      = 4,
    parameter int NOTE_W          = $clog2(NUM_NOTES),
    parameter int AGE_W           = 16,
    parameter int RELEASE_TIMEOUT = 5_000_000
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic [NUM_NOTES-1:0]               gate_in,
    input  logic [NUM_VOICES-1:0]              adsr_idle_in,
    output logic [NUM_VOICES*NOTE_W-1:0]       voice_note_out,
    output logic [NUM_VOICES-1:0]              voice_active_out,
    output logic [NUM_VOICES-1:0]              voice_hold_out,
    output logic [NUM_VOICES-1:0]              voice_start_out,
    output logic [$clog2(NUM_VOICES+1)-1:0]    num_voices_out,
    output logic                               steal_out,
    output logic                               drop_out
);

    localparam int SLOT_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CNT_W  = $clog2(RELEASE_TIMEOUT + 1);
    localparam int NV_W   = $clog2(NUM_VOICES + 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = '1;
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_TIMEOUT - 1);
    // Cycles during which a freshly started ADSR's idle flag is still stale.
    localparam logic [1:0] HOLDOFF = 2'd2;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_HOLD    = 2'd1,
        SLOT_RELEASE = 2'd2
    } slot_state_e;

    slot_state_e        state_q   [NUM_VOICES];
    logic [NOTE_W-1:0]  note_q    [NUM_VOICES];
    logic [AGE_W-1:0]   age_q     [NUM_VOICES];
    logic [CNT_W-1:0]   rel_cnt_q [NUM_VOICES];
    logic [1:0]         holdoff_q [NUM_VOICES];

    logic [NUM_NOTES-1:0]  gate_q;
    logic [NUM_NOTES-1:0]  pending_q;
    logic [NUM_NOTES-1:0]  pending_d;
    logic [NUM_VOICES-1:0] start_q;

    logic [NUM_NOTES-1:0]  rise;
    logic [NUM_NOTES-1:0]  fall;

    logic                  serve_vld;
    logic [NOTE_W-1:0]     serve_note;

    logic                  own_vld;
    logic [SLOT_W-1:0]     own_idx;
    logic                  free_vld;
    logic [SLOT_W-1:0]     free_idx;
    logic                  rel_vld;
    logic [SLOT_W-1:0]     rel_idx;
    logic [AGE_W-1:0]      rel_age;

    logic                  alloc_vld;
    logic [SLOT_W-1:0]     alloc_idx;

`ifdef VOICE_STEAL_EN
    logic                  hold_vld;
    logic [SLOT_W-1:0]     hold_idx;
    logic [AGE_W-1:0]      hold_age;
    logic                  alloc_steal;
    logic                  steal_q;
`else
    logic                  alloc_drop;
    logic                  drop_q;
`endif

    // Gate edges are taken against the registered previous level.
    assign rise = gate_in & ~gate_q;
    assign fall = ~gate_in & gate_q;

    // Pick the lowest pending note-on that is not being released this same cycle.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch can be inferred.
        serve_vld  = 1'b0;
        serve_note = '0;
        for (int p = NUM_NOTES - 1; p >= 0; p--) begin
            if (pending_q[p] && !fall[p]) begin
                serve_vld  = 1'b1;
                serve_note = NOTE_W'(p);
            end
        end
    end

    // Candidate slots: owner of the note, lowest FREE, oldest RELEASE (and oldest HOLD).
    always_comb begin
        own_vld  = 1'b0;
        own_idx  = '0;
        free_vld = 1'b0;
        free_idx = '0;
        rel_vld  = 1'b0;
        rel_idx  = '0;
        rel_age  = '0;
`ifdef VOICE_STEAL_EN
        hold_vld = 1'b0;
        hold_idx = '0;
        hold_age = '0;
`endif
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (state_q[i] != SLOT_FREE && note_q[i] == serve_note && !own_vld) begin
                own_vld = 1'b1;
                own_idx = SLOT_W'(i);
            end
            if (state_q[i] == SLOT_FREE && !free_vld) begin
                free_vld = 1'b1;
                free_idx = SLOT_W'(i);
            end
            // Strict comparison keeps the lowest index on equal ages.
            if (state_q[i] == SLOT_RELEASE && (!rel_vld || age_q[i] > rel_age)) begin
                rel_vld = 1'b1;
                rel_idx = SLOT_W'(i);
                rel_age = age_q[i];
            end
`ifdef VOICE_STEAL_EN
            if (state_q[i] == SLOT_HOLD && (!hold_vld || age_q[i] > hold_age)) begin
                hold_vld = 1'b1;
                hold_idx = SLOT_W'(i);
                hold_age = age_q[i];
            end
`endif
        end
    end

    // Resolve the slot for the served note by priority, or mark it stolen/dropped.
    always_comb begin
        alloc_vld = 1'b0;
        alloc_idx = '0;
`ifdef VOICE_STEAL_EN
        alloc_steal = 1'b0;
`else
        alloc_drop  = 1'b0;
`endif
        if (serve_vld) begin
            if (own_vld) begin
                alloc_vld = 1'b1;
                alloc_idx = own_idx;
            end else if (free_vld) begin
                alloc_vld = 1'b1;
                alloc_idx = free_idx;
            end else if (rel_vld) begin
                alloc_vld = 1'b1;
                alloc_idx = rel_idx;
            end else begin
`ifdef VOICE_STEAL_EN
                alloc_vld   = hold_vld;
                alloc_idx   = hold_idx;
                alloc_steal = hold_vld;
`else
                alloc_drop  = 1'b1;
`endif
            end
        end
    end

    // Served note leaves the queue whether allocated or dropped; note-off cancels a queued note.
    always_comb begin
        pending_d = pending_q;
        if (serve_vld) begin
            pending_d[serve_note] = 1'b0;
        end
        pending_d = (pending_d | rise) & ~fall;
    end

    // Slot state machines, ages, release timers and registered pulse outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            // NOTE: the per-slot arrays are a handful of flops, not RAM, so they are reset like any register.
            gate_q    <= '0;
            pending_q <= '0;
            start_q   <= '0;
`ifdef VOICE_STEAL_EN
            steal_q   <= 1'b0;
`else
            drop_q    <= 1'b0;
`endif
            for (int i = 0; i < NUM_VOICES; i++) begin
                state_q[i]   <= SLOT_FREE;
                note_q[i]    <= '0;
                age_q[i]     <= '0;
                rel_cnt_q[i] <= '0;
                holdoff_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments; the later allocation write overrides the
            // earlier state-progress write for the same slot, so allocation wins.
            gate_q    <= gate_in;
            pending_q <= pending_d;
            start_q   <= '0;
`ifdef VOICE_STEAL_EN
            steal_q   <= alloc_steal;
`else
            drop_q    <= alloc_drop;
`endif
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (holdoff_q[i] != 2'd0) begin
                    holdoff_q[i] <= holdoff_q[i] - 2'd1;
                end
                if (state_q[i] != SLOT_FREE && age_q[i] != AGE_MAX) begin
                    age_q[i] <= age_q[i] + AGE_W'(1);
                end
                case (state_q[i])
                    SLOT_HOLD: begin
                        if (fall[note_q[i]]) begin
                            state_q[i]   <= SLOT_RELEASE;
                            rel_cnt_q[i] <= '0;
                        end
                    end
                    SLOT_RELEASE: begin
                        if ((adsr_idle_in[i] && holdoff_q[i] == 2'd0) || rel_cnt_q[i] == REL_LAST) begin
                            state_q[i] <= SLOT_FREE;
                        end else begin
                            rel_cnt_q[i] <= rel_cnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
                if (alloc_vld && alloc_idx == SLOT_W'(i)) begin
                    state_q[i]   <= SLOT_HOLD;
                    note_q[i]    <= serve_note;
                    age_q[i]     <= '0;
                    holdoff_q[i] <= HOLDOFF;
                    start_q[i]   <= 1'b1;
                end
            end
        end
    end

    // Output decode straight from the registered slot state.
    always_comb begin
        voice_note_out   = '0;
        voice_active_out = '0;
        voice_hold_out   = '0;
        num_voices_out   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_note_out[i*NOTE_W +: NOTE_W] = note_q[i];
            voice_active_out[i] = (state_q[i] != SLOT_FREE);
            voice_hold_out[i]   = (state_q[i] == SLOT_HOLD);
            if (state_q[i] != SLOT_FREE) begin
                num_voices_out = num_voices_out + NV_W'(1);
            end
        end
    end

    assign voice_start_out = start_q;
`ifdef VOICE_STEAL_EN
    assign steal_out = steal_q;
    assign drop_out  = 1'b0;
`else
    assign steal_out = 1'b0;
    assign drop_out  = drop_q;
`endif

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed scenarios followed by random gate/idle traffic,
// compared every cycle against a behavioural slot model. Release timeout and
// age width are shrunk so timeouts and age saturation occur within the run.
module tb_voice_allocator;

    localparam int NN      = 8;
    localparam int NV      = 4;
    localparam int NW      = 3;
    localparam int AW      = 4;
    localparam int T       = 30;
    localparam int AGE_MAX = (1 << AW) - 1;

    logic              clk;
    logic              rst_in;
    logic [NN-1:0]     gate_in;
    logic [NV-1:0]     adsr_idle_in;
    logic [NV*NW-1:0]  voice_note_out;
    logic [NV-1:0]     voice_active_out;
    logic [NV-1:0]     voice_hold_out;
    logic [NV-1:0]     voice_start_out;
    logic [2:0]        num_voices_out;
    logic              steal_out;
    logic              drop_out;

    int total = 0;
    int bad   = 0;

    // Model state: slot status 0=free 1=hold 2=release
    int        m_st    [NV];
    int        m_note  [NV];
    int        m_age   [NV];
    int        m_rel   [NV];
    int        m_since [NV];
    logic [NN-1:0] m_gate;
    logic [NN-1:0] m_pend;
    logic [NV-1:0] e_start;
    logic          e_steal;
    logic          e_drop;

    voice_allocator #(
        .NUM_NOTES(NN), .NUM_VOICES(NV), .NOTE_W(NW), .AGE_W(AW), .RELEASE_TIMEOUT(T)
    ) dut (
        .clk_in(clk),
        .rst_in(rst_in),
        .gate_in(gate_in),
        .adsr_idle_in(adsr_idle_in),
        .voice_note_out(voice_note_out),
        .voice_active_out(voice_active_out),
        .voice_hold_out(voice_hold_out),
        .voice_start_out(voice_start_out),
        .num_voices_out(num_voices_out),
        .steal_out(steal_out),
        .drop_out(drop_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NV; i++) begin
            m_st[i] = 0; m_note[i] = 0; m_age[i] = 0; m_rel[i] = 0; m_since[i] = 2;
        end
        m_gate = '0; m_pend = '0; e_start = '0; e_steal = 1'b0; e_drop = 1'b0;
    endtask

    function automatic int oldest(input int st[NV], input int age[NV], input int want);
        int best = -1;
        for (int i = 0; i < NV; i++) begin
            if (st[i] == want && (best < 0 || age[i] > age[best])) best = i;
        end
        return best;
    endfunction

    // One clock edge of the reference behaviour, using pre-edge slot status for choices.
    task automatic model_edge(input logic [NN-1:0] g, input logic [NV-1:0] idle);
        logic [NN-1:0] rise, fall;
        int srv, pick;
        int o_st [NV];
        int o_age[NV];
        bit is_steal;
        rise = g & ~m_gate;
        fall = ~g & m_gate;
        srv = -1;
        for (int p = 0; p < NN; p++) if (srv < 0 && m_pend[p] && !fall[p]) srv = p;
        for (int i = 0; i < NV; i++) begin o_st[i] = m_st[i]; o_age[i] = m_age[i]; end
        e_start = '0; e_steal = 1'b0; e_drop = 1'b0;
        for (int i = 0; i < NV; i++) begin
            if (o_st[i] == 1 && fall[m_note[i]]) begin
                m_st[i] = 2; m_rel[i] = 0;
            end else if (o_st[i] == 2) begin
                if ((idle[i] && m_since[i] >= 2) || m_rel[i] == T - 1) m_st[i] = 0;
                else m_rel[i]++;
            end
            if (o_st[i] != 0 && m_age[i] < AGE_MAX) m_age[i]++;
            if (m_since[i] < 2) m_since[i]++;
        end
        if (srv >= 0) begin
            pick = -1; is_steal = 1'b0;
            for (int i = 0; i < NV; i++) if (pick < 0 && o_st[i] != 0 && m_note[i] == srv) pick = i;
            for (int i = 0; i < NV; i++) if (pick < 0 && o_st[i] == 0) pick = i;
            if (pick < 0) pick = oldest(o_st, o_age, 2);
`ifdef VOICE_STEAL_EN
            if (pick < 0) begin
                pick = oldest(o_st, o_age, 1);
                is_steal = (pick >= 0);
            end
`endif
            if (pick >= 0) begin
                m_st[pick] = 1; m_note[pick] = srv; m_age[pick] = 0; m_since[pick] = 0;
                e_start[pick] = 1'b1; e_steal = is_steal;
            end else begin
                e_drop = 1'b1;
            end
            m_pend[srv] = 1'b0;
        end
        m_pend = (m_pend | rise) & ~fall;
        m_gate = g;
    endtask

    task automatic check_all(input string tag);
        logic [NV*NW-1:0] en;
        logic [NV-1:0] ea, eh;
        int num;
        en = '0; ea = '0; eh = '0; num = 0;
        for (int i = 0; i < NV; i++) begin
            en[i*NW +: NW] = NW'(m_note[i]);
            ea[i] = (m_st[i] != 0);
            eh[i] = (m_st[i] == 1);
            if (m_st[i] != 0) num++;
        end
        check({tag, "/note"},   32'(voice_note_out),   32'(en));
        check({tag, "/active"}, 32'(voice_active_out), 32'(ea));
        check({tag, "/hold"},   32'(voice_hold_out),   32'(eh));
        check({tag, "/start"},  32'(voice_start_out),  32'(e_start));
        check({tag, "/num"},    32'(num_voices_out),   32'(num));
        check({tag, "/steal"},  32'(steal_out),        32'(e_steal));
        check({tag, "/drop"},   32'(drop_out),         32'(e_drop));
    endtask

    task automatic step(input string tag, input logic [NN-1:0] g, input logic [NV-1:0] idle);
        gate_in = g;
        adsr_idle_in = idle;
        @(posedge clk);
        model_edge(g, idle);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [NN-1:0] rg;
        logic [NV-1:0] ri;
        int k;

        m_reset();
        rst_in = 1'b0;
        gate_in = '0;
        adsr_idle_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        check("reset_num", 32'(num_voices_out), 32'd0);
        rst_in = 1'b1;
        step("idle0", 8'h00, 4'h0);
        step("idle1", 8'h00, 4'h0);

        // Two notes at once: slot0 note0 two edges later, slot1 note2 one edge after that.
        step("n05_e1", 8'h05, 4'h0);
        check("n05_e1_start", 32'(voice_start_out), 32'h0);
        step("n05_e2", 8'h05, 4'h0);
        check("n05_e2_start", 32'(voice_start_out), 32'h1);
        check("n05_e2_note0", 32'(voice_note_out[2:0]), 32'd0);
        check("n05_e2_hold",  32'(voice_hold_out), 32'h1);
        step("n05_e3", 8'h05, 4'h0);
        check("n05_e3_start", 32'(voice_start_out), 32'h2);
        check("n05_e3_note1", 32'(voice_note_out[5:3]), 32'd2);
        check("n05_e3_num",   32'(num_voices_out), 32'd2);
        repeat (4) step("n05_hold", 8'h05, 4'h0);

        // Note-off on note0 then idle after ten cycles frees slot0.
        step("off0", 8'h04, 4'h0);
        check("off0_hold",   32'(voice_hold_out), 32'h2);
        check("off0_active", 32'(voice_active_out), 32'h3);
        repeat (9) step("rel0", 8'h04, 4'h0);
        step("idle_free", 8'h04, 4'h1);
        check("idle_free_active", 32'(voice_active_out), 32'h2);

        // Retrigger while in RELEASE: same slot restarts, note unchanged.
        repeat (3) step("regate", 8'h05, 4'h0);
        repeat (3) step("rel_again", 8'h04, 4'h0);
        check("rel_again_active", 32'(voice_active_out), 32'h3);
        step("retrig_e1", 8'h05, 4'h0);
        step("retrig_e2", 8'h05, 4'h0);
        check("retrig_start", 32'(voice_start_out), 32'h1);
        check("retrig_note",  32'(voice_note_out[2:0]), 32'd0);
        check("retrig_hold",  32'(voice_hold_out), 32'h3);

        // Drain everything, then fill all four slots and present a fifth note.
        repeat (6) step("drain", 8'h00, 4'hF);
        check("drain_num", 32'(num_voices_out), 32'd0);
        repeat (8) step("fill", 8'h0F, 4'h0);
        check("fill_num", 32'(num_voices_out), 32'd4);
        step("fifth_e1", 8'h1F, 4'h0);
        step("fifth_e2", 8'h1F, 4'h0);
`ifdef VOICE_STEAL_EN
        check("fifth_steal", 32'(steal_out), 32'd1);
        check("fifth_start", 32'(voice_start_out), 32'h1);
        check("fifth_note",  32'(voice_note_out[2:0]), 32'd4);
`else
        check("fifth_drop",  32'(drop_out), 32'd1);
        check("fifth_start", 32'(voice_start_out), 32'h0);
        check("fifth_notes", 32'(voice_note_out), 32'h688);
`endif
        repeat (3) step("fifth_after", 8'h1F, 4'h0);

        // Release everything with idle low: forced free after exactly T cycles.
        step("to_off", 8'h00, 4'h0);
        k = 0;
        while (voice_active_out != '0 && k < T + 10) begin
            step("to_wait", 8'h00, 4'h0);
            k++;
        end
        check("timeout_cycles", 32'(k), 32'(T));

        // Random traffic with a reset asserted mid-operation.
        rg = '0;
        for (int n = 0; n < 2500; n++) begin
            for (int b = 0; b < NN; b++) if ($urandom_range(0, 7) == 0) rg[b] = ~rg[b];
            for (int b = 0; b < NV; b++) ri[b] = ($urandom_range(0, 5) == 0);
            step("rand", rg, ri);
            if (n == 1200) begin
                #3;
                rst_in = 1'b0;
                #1;
                m_reset();
                check("midrst_start",  32'(voice_start_out), 32'h0);
                check("midrst_active", 32'(voice_active_out), 32'h0);
                check_all("midrst");
                @(posedge clk);
                #1;
                rst_in = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
